mat_operand_result_buffer: RTL

Parametrised successor to the fixed 4x4/3x3/2x2 operand/result memory. Latches one operand set (A: A_DIM x A_DIM, B: B_DIM x B_DIM) on a run request and presents it to the compute engines (PE, 3x3 SA, 2x2 SA, ...). Collects one C_DIM x C_DIM result per source into NUM_SRC independent banks. Signals completion once every bank is filled. Adds an explicit state machine, a per-bank fill mask, a sticky error flag and a soft clear.

---
 rtl/mat_operand_result_buffer_pkg.sv | 21 ++
 rtl/mat_operand_result_buffer_result_bank.sv | 47 ++++
 rtl/mat_operand_result_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mat_operand_result_buffer_pkg.sv
// Shared types and defaults for the operand/result buffer.
package mat_buf_pkg;

   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_A_DIM   = 4;
   localparam int unsigned DEF_B_DIM   = 3;
   localparam int unsigned DEF_C_DIM   = 2;
   localparam int unsigned DEF_NUM_SRC = 3;

   // Result source / bank indices
   localparam int unsigned SRC_PE  = 0;
   localparam int unsigned SRC_SA3 = 1;
   localparam int unsigned SRC_SA2 = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/mat_operand_result_buffer_result_bank.sv
// One result bank: holds a single C matrix and a filled flag.
module result_bank #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         unfill_i,
   input  logic         we_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic         filled_o
);

   logic [W-1:0] data_q, data_d;
   logic         filled_q, filled_d;

   // Next-state: soft clear wipes everything, unfill drops only the flag
   always_comb begin
      data_d   = data_q;
      filled_d = filled_q;
      if (clear_i) begin
         data_d   = '0;
         filled_d = 1'b0;
      end else if (unfill_i) begin
         filled_d = 1'b0;
      end else if (we_i) begin
         data_d   = d_i;
         filled_d = 1'b1;
      end
   end

   // Storage registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q   <= '0;
         filled_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         filled_q <= filled_d;
      end
   end

   assign q_o      = data_q;
   assign filled_o = filled_q;

endmodule

// File: rtl/mat_operand_result_buffer.sv
// Operand latch plus per-source result banks with completion and error tracking.
module mat_operand_result_buffer
   import mat_buf_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned A_DIM   = DEF_A_DIM,
   parameter int unsigned B_DIM   = DEF_B_DIM,
   parameter int unsigned C_DIM   = DEF_C_DIM,
   parameter int unsigned NUM_SRC = DEF_NUM_SRC,
   parameter int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              run_valid_i,
   input  logic [A_DIM*A_DIM*DATA_W-1:0]     a_i,
   input  logic [B_DIM*B_DIM*DATA_W-1:0]     b_i,
   output logic [A_DIM*A_DIM*DATA_W-1:0]     a_o,
   output logic [B_DIM*B_DIM*DATA_W-1:0]     b_o,
   output logic                              opnd_ready_o,
   input  logic                              res_valid_i,
   input  logic [SRC_W-1:0]                  res_src_i,
   input  logic [C_DIM*C_DIM*DATA_W-1:0]     c_i,
   output logic [NUM_SRC*C_DIM*C_DIM*DATA_W-1:0] c_o,
   output logic [NUM_SRC-1:0]                res_mask_o,
   output logic                              done_capture,
   input  logic                              clear_i,
   output logic                              err_o
);

   localparam int unsigned AW = A_DIM * A_DIM * DATA_W;
   localparam int unsigned BW = B_DIM * B_DIM * DATA_W;
   localparam int unsigned CW = C_DIM * C_DIM * DATA_W;

   state_e              state_q, state_d;
   logic [AW-1:0]       a_q, a_d;
   logic [BW-1:0]       b_q, b_d;
   logic                rdy_q, rdy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                run_q, run_d;
   logic                run_rise;
   logic [NUM_SRC-1:0]  wr_sel;
   logic [NUM_SRC-1:0]  bank_we;
   logic [NUM_SRC-1:0]  res_mask;
   logic                src_ok;
   logic                unfill;

   assign run_rise = run_valid_i & ~run_q;
   assign run_d    = run_valid_i;

   // One-hot decode of the target bank; empty when the index is out of range
   always_comb begin
      wr_sel = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         wr_sel[k] = (32'(res_src_i) == k);
      end
      src_ok = |wr_sel;
   end

   // FSM next-state, operand latch and error tracking
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rdy_d   = rdy_q;
      done_d  = done_q;
      err_d   = err_q;
      bank_we = '0;
      unfill  = 1'b0;
      if (clear_i) begin
         state_d = ST_IDLE;
         a_d     = '0;
         b_d     = '0;
         rdy_d   = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_rise) begin
                  a_d     = a_i;
                  b_d     = b_i;
                  rdy_d   = 1'b1;
                  state_d = ST_LOADED;
               end else if (res_valid_i) begin
                  err_d = 1'b1;
               end
            end
            ST_LOADED: begin
               if (run_rise) begin
                  a_d    = a_i;
                  b_d    = b_i;
                  unfill = 1'b1;
               end else if (res_valid_i) begin
                  if (!src_ok || |(wr_sel & res_mask)) begin
                     err_d = 1'b1;
                  end else begin
                     bank_we = wr_sel;
                     if (&(res_mask | wr_sel)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (run_rise) begin
                  a_d     = a_i;
                  b_d     = b_i;
                  unfill  = 1'b1;
                  done_d  = 1'b0;
                  state_d = ST_LOADED;
               end else if (res_valid_i) begin
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Control and operand registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         run_q   <= run_d;
      end
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_bank
      result_bank #(.W(CW)) u_bank (
         .clk      (clk),
         .reset    (reset),
         .clear_i  (clear_i),
         .unfill_i (unfill),
         .we_i     (bank_we[k]),
         .d_i      (c_i),
         .q_o      (c_o[k*CW +: CW]),
         .filled_o (res_mask[k])
      );
   end

   assign a_o          = a_q;
   assign b_o          = b_q;
   assign opnd_ready_o = rdy_q;
   assign done_capture = done_q;
   assign err_o        = err_q;
   assign res_mask_o   = res_mask;

endmodule
